// File: rtl/ptp_fifo_ka10.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ptp_fifo_ka10
// Purpose  : KA10 paper tape punch controller. A character FIFO sits between
//            DATAO and the front-end read port.
// Options  : PTP_OVERRUN_EN - a DATAO into a full FIFO latches the overrun flag
// Revision : 1.0 - initial release
// ============================================================================
module ptp_fifo_ka10 #(
    parameter logic [6:0] DEVICE = 7'o020,
    parameter int         DEPTH  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iobus_iob_poweron,
    input  logic        iobus_iob_reset,
    input  logic        iobus_datao_clear,
    input  logic        iobus_datao_set,
    input  logic        iobus_cono_clear,
    input  logic        iobus_cono_set,
    input  logic        iobus_iob_fm_datai,
    input  logic        iobus_iob_fm_status,
    input  logic [3:9]  iobus_ios,
    input  logic [0:35] iobus_iob_in,
    output logic [1:7]  iobus_pi_req,
    output logic [0:35] iobus_iob_out,
    input  logic        key_tape_feed,
    input  logic        s_read,
    output logic [31:0] s_readdata,
    output logic        fe_data_rq
);

    localparam int            AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   c_DEPTH_CNT = (AW+1)'(DEPTH);

    // ------------------------------------------------------------------
    // Bus strobe edge detection
    // ------------------------------------------------------------------
    logic r_datao_clr_d;
    logic r_datao_set_d;
    logic r_cono_clr_d;
    logic r_cono_set_d;

    logic w_sel;
    logic w_pwr_clr;
    logic w_sclr;
    logic w_datao_clr;
    logic w_datao_set;
    logic w_cono_clr;
    logic w_cono_set;

    assign w_sel     = (iobus_ios == DEVICE);
    assign w_pwr_clr = ~iobus_iob_poweron;
    assign w_sclr    = w_pwr_clr | iobus_iob_reset;

    assign w_datao_clr = iobus_datao_clear & ~r_datao_clr_d & w_sel;
    assign w_datao_set = iobus_datao_set   & ~r_datao_set_d & w_sel;
    assign w_cono_clr  = iobus_cono_clear  & ~r_cono_clr_d  & w_sel;
    assign w_cono_set  = iobus_cono_set    & ~r_cono_set_d  & w_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_datao_clr_d <= 1'b0;
            r_datao_set_d <= 1'b0;
            r_cono_clr_d  <= 1'b0;
            r_cono_set_d  <= 1'b0;
        end else if (w_pwr_clr) begin
            r_datao_clr_d <= 1'b0;
            r_datao_set_d <= 1'b0;
            r_cono_clr_d  <= 1'b0;
            r_cono_set_d  <= 1'b0;
        end else begin
            r_datao_clr_d <= iobus_datao_clear;
            r_datao_set_d <= iobus_datao_set;
            r_cono_clr_d  <= iobus_cono_clear;
            r_cono_set_d  <= iobus_cono_set;
        end
    end

    // ------------------------------------------------------------------
    // Character FIFO
    // ------------------------------------------------------------------
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [AW:0]   w_count_nxt;

    logic       w_empty;
    logic       w_full;
    logic       w_pop;
    logic       w_push;
    logic       w_drop;
    logic [7:0] w_char;

    logic [2:0] r_pia;
    logic       r_done;
    logic       r_binary;
    logic       w_overrun;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_DEPTH_CNT);
    assign w_pop   = s_read & ~w_empty;
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign w_push  = w_datao_set & (~w_full | w_pop);
    assign w_drop  = w_datao_set & w_full & ~w_pop;
    assign w_char  = r_binary ? {2'b10, iobus_iob_in[30:35]} : iobus_iob_in[28:35];

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_sclr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_char;
        end
    end

    // ------------------------------------------------------------------
    // Status register
    // ------------------------------------------------------------------
    logic [2:0] w_pia_nxt;
    logic       w_done_nxt;
    logic       w_binary_nxt;

    // Sequential overrides: CONO clear, CONO set, DATAO clear, then FIFO activity.
    always_comb begin
        w_pia_nxt    = r_pia;
        w_done_nxt   = r_done;
        w_binary_nxt = r_binary;
        if (w_cono_clr) begin
            w_pia_nxt    = 3'b000;
            w_done_nxt   = 1'b0;
            w_binary_nxt = 1'b0;
        end
        if (w_cono_set) begin
            w_pia_nxt    = w_pia_nxt | iobus_iob_in[33:35];
            w_done_nxt   = w_done_nxt | iobus_iob_in[32];
            w_binary_nxt = w_binary_nxt | iobus_iob_in[30];
        end
        if (w_datao_clr) begin
            w_done_nxt = 1'b0;
        end
        if ((w_push | w_pop) && (w_count_nxt < c_DEPTH_CNT)) begin
            w_done_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pia    <= 3'b000;
            r_done   <= 1'b0;
            r_binary <= 1'b0;
        end else if (w_sclr) begin
            r_pia    <= 3'b000;
            r_done   <= 1'b0;
            r_binary <= 1'b0;
        end else begin
            r_pia    <= w_pia_nxt;
            r_done   <= w_done_nxt;
            r_binary <= w_binary_nxt;
        end
    end

`ifdef PTP_OVERRUN_EN
    logic r_overrun;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_sclr) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (w_cono_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign w_overrun = r_overrun;
`else
    logic w_unused_drop;

    assign w_overrun     = 1'b0;
    assign w_unused_drop = w_drop;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic w_busy;
    logic w_unused_bits;

    assign w_busy        = ~w_empty;
    assign fe_data_rq    = w_busy | key_tape_feed;
    assign w_unused_bits = ^{iobus_iob_fm_datai, iobus_iob_in[0:27]};

    for (genvar n = 1; n <= 7; n++) begin : g_pi
        assign iobus_pi_req[n] = r_done & (r_pia == 3'(n));
    end

    // DATAI has nothing to return, so only CONI drives the bus.
    always_comb begin
        iobus_iob_out = '0;
        if (iobus_iob_fm_status && w_sel) begin
            iobus_iob_out[29:35] = {w_overrun, r_binary, w_busy, r_done, r_pia};
        end
    end

    // Queued data always wins over blank feed frames.
    always_comb begin
        s_readdata = '0;
        if (s_read) begin
            if (!w_empty) begin
                s_readdata = {23'b0, 1'b1, r_mem[r_rd_ptr]};
            end else if (key_tape_feed) begin
                s_readdata = 32'h0000_0100;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ptp_fifo_ka10.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ptp_fifo_ka10
// Purpose  : Self-checking bench for ptp_fifo_ka10 against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ptp_fifo_ka10;

    localparam int         DEPTH = 8;
    localparam logic [6:0] DEV   = 7'o020;

    logic        clk;
    logic        reset;
    logic        iobus_iob_poweron;
    logic        iobus_iob_reset;
    logic        iobus_datao_clear;
    logic        iobus_datao_set;
    logic        iobus_cono_clear;
    logic        iobus_cono_set;
    logic        iobus_iob_fm_datai;
    logic        iobus_iob_fm_status;
    logic [3:9]  iobus_ios;
    logic [0:35] iobus_iob_in;
    logic [1:7]  iobus_pi_req;
    logic [0:35] iobus_iob_out;
    logic        key_tape_feed;
    logic        s_read;
    logic [31:0] s_readdata;
    logic        fe_data_rq;

    ptp_fifo_ka10 #(
        .DEVICE (DEV),
        .DEPTH  (DEPTH)
    ) u_dut (
        .clk                 (clk),
        .reset               (reset),
        .iobus_iob_poweron   (iobus_iob_poweron),
        .iobus_iob_reset     (iobus_iob_reset),
        .iobus_datao_clear   (iobus_datao_clear),
        .iobus_datao_set     (iobus_datao_set),
        .iobus_cono_clear    (iobus_cono_clear),
        .iobus_cono_set      (iobus_cono_set),
        .iobus_iob_fm_datai  (iobus_iob_fm_datai),
        .iobus_iob_fm_status (iobus_iob_fm_status),
        .iobus_ios           (iobus_ios),
        .iobus_iob_in        (iobus_iob_in),
        .iobus_pi_req        (iobus_pi_req),
        .iobus_iob_out       (iobus_iob_out),
        .key_tape_feed       (key_tape_feed),
        .s_read              (s_read),
        .s_readdata          (s_readdata),
        .fe_data_rq          (fe_data_rq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: punch buffer contents and status bits.
    logic [7:0] q[$];
    logic [2:0] m_pia;
    logic       m_done;
    logic       m_binary;
    logic       m_overrun;

    task automatic check_val(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear;
        q.delete();
        m_pia     = 3'b000;
        m_done    = 1'b0;
        m_binary  = 1'b0;
        m_overrun = 1'b0;
    endtask

    function automatic logic [6:0] pick_ios(input bit on_sel);
        return on_sel ? DEV : (DEV ^ 7'($urandom_range(1, 127)));
    endfunction

    function automatic logic [35:0] exp_coni();
        return {29'b0, m_overrun, m_binary, (q.size() != 0), m_done, m_pia};
    endfunction

    function automatic logic [1:7] exp_pi();
        logic [1:7] v;
        v = '0;
        if (m_done && m_pia != 3'd0) v[m_pia] = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] read_exp();
        if (q.size() != 0) return {23'b0, 1'b1, q[0]};
        if (key_tape_feed) return 32'h100;
        return 32'h0;
    endfunction

    task automatic check_status(input bit on_sel);
        iobus_ios           = pick_ios(on_sel);
        iobus_iob_fm_status = 1'b1;
        @(negedge clk);
        check_val("coni", iobus_iob_out, on_sel ? exp_coni() : 36'b0);
        check_val("pi_req", iobus_pi_req, exp_pi());
        check_val("fe_data_rq", fe_data_rq, (q.size() != 0) | key_tape_feed);
        iobus_iob_fm_status = 1'b0;
        iobus_ios           = DEV;
        tick();
    endtask

    task automatic do_read;
        s_read = 1'b1;
        @(negedge clk);
        check_val("s_readdata", s_readdata, read_exp());
        @(posedge clk);
        #1;
        s_read = 1'b0;
        if (q.size() != 0) begin
            void'(q.pop_front());
            m_done = 1'b1;
        end
    endtask

    task automatic do_datao(input logic [35:0] d, input bit on_sel, input bit with_pop);
        bit         full;
        bit         popped;
        bit         push_ok;
        logic [7:0] ch;
        iobus_ios         = pick_ios(on_sel);
        iobus_iob_in      = d;
        iobus_datao_clear = 1'b1;
        tick();
        iobus_datao_clear = 1'b0;
        if (on_sel) m_done = 1'b0;
        iobus_datao_set = 1'b1;
        s_read          = with_pop;
        if (with_pop) begin
            @(negedge clk);
            check_val("rd_with_push", s_readdata, read_exp());
        end
        @(posedge clk);
        #1;
        s_read  = 1'b0;
        full    = (q.size() == DEPTH);
        popped  = with_pop && (q.size() != 0);
        push_ok = 1'b0;
        if (popped) void'(q.pop_front());
        if (on_sel) begin
            ch      = m_binary ? {2'b10, d[5:0]} : d[7:0];
            push_ok = !full || popped;
            if (push_ok) q.push_back(ch);
`ifdef PTP_OVERRUN_EN
            else m_overrun = 1'b1;
`endif
        end
        if ((popped || push_ok) && q.size() < DEPTH) m_done = 1'b1;
        tick();
        iobus_datao_set = 1'b0;
        tick();
        iobus_ios = DEV;
    endtask

    task automatic do_cono(input bit clr, input logic [35:0] d, input bit on_sel);
        iobus_ios        = pick_ios(on_sel);
        iobus_iob_in     = d;
        iobus_cono_clear = clr;
        iobus_cono_set   = 1'b1;
        tick();
        tick();
        iobus_cono_clear = 1'b0;
        iobus_cono_set   = 1'b0;
        tick();
        iobus_ios = DEV;
        if (on_sel) begin
            if (clr) begin
                m_pia     = 3'b000;
                m_done    = 1'b0;
                m_binary  = 1'b0;
                m_overrun = 1'b0;
            end
            m_pia    = m_pia | d[2:0];
            m_done   = m_done | d[3];
            m_binary = m_binary | d[5];
        end
    endtask

    task automatic do_iob_reset;
        iobus_iob_reset = 1'b1;
        tick();
        iobus_iob_reset = 1'b0;
        model_clear();
    endtask

    function automatic logic [35:0] rand36();
        return {4'($urandom), 32'($urandom)};
    endfunction

    initial begin
        reset               = 1'b1;
        iobus_iob_poweron   = 1'b1;
        iobus_iob_reset     = 1'b0;
        iobus_datao_clear   = 1'b0;
        iobus_datao_set     = 1'b0;
        iobus_cono_clear    = 1'b0;
        iobus_cono_set      = 1'b0;
        iobus_iob_fm_datai  = 1'b0;
        iobus_iob_fm_status = 1'b0;
        iobus_ios           = DEV;
        iobus_iob_in        = '0;
        key_tape_feed       = 1'b0;
        s_read              = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        s_read = 1'b1;
        @(negedge clk);
        check_val("reset_readdata", s_readdata, 32'h0);
        tick();
        s_read = 1'b0;
        check_status(1'b1);

        // Tape feed with an empty FIFO
        do_iob_reset();
        key_tape_feed = 1'b1;
        check_status(1'b1);
        repeat (20) tick();
        do_read();
        check_status(1'b1);
        key_tape_feed = 1'b0;

        // Binary mode character
        do_cono(1'b1, 36'o60, 1'b1);
        do_datao(36'o177, 1'b1, 1'b0);
        check_status(1'b1);
        do_read();
        check_status(1'b1);

        // Alpha mode with PI channel 3
        do_cono(1'b1, 36'o3, 1'b1);
        do_datao(36'o321, 1'b1, 1'b0);
        @(negedge clk);
        check_val("pi_pia3", iobus_pi_req, 7'b0010000);
        tick();
        check_status(1'b1);
        do_read();

        // Fill past capacity
        do_cono(1'b1, 36'o0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            do_datao(rand36(), 1'b1, 1'b0);
            if (i >= 7) check_status(1'b1);
        end
        do_read();
        check_status(1'b1);
        for (int i = 0; i < 8; i++) do_read();

        // Concurrent push/pop across pointer wrap
        for (int i = 0; i < 4; i++) do_datao(rand36(), 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) do_datao(rand36(), 1'b1, 1'b1);
        check_status(1'b1);
        for (int i = 0; i < 5; i++) do_read();

        // Push into full FIFO with a simultaneous pop
        for (int i = 0; i < DEPTH; i++) do_datao(rand36(), 1'b1, 1'b0);
        do_datao(rand36(), 1'b1, 1'b1);
        check_status(1'b1);

        // Power-on low clears synchronously
        iobus_iob_poweron = 1'b0;
        tick();
        iobus_iob_poweron = 1'b1;
        model_clear();
        check_status(1'b1);
        do_read();

        // Async reset mid-drain
        do_cono(1'b1, 36'o15, 1'b1);
        for (int i = 0; i < 3; i++) do_datao(rand36(), 1'b1, 1'b0);
        do_read();
        iobus_iob_fm_status = 1'b1;
        s_read              = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check_val("arst_readdata", s_readdata, 32'h0);
        check_val("arst_coni", iobus_iob_out, 36'h0);
        check_val("arst_pi", iobus_pi_req, 7'h0);
        check_val("arst_fe_rq", fe_data_rq, key_tape_feed);
        s_read              = 1'b0;
        iobus_iob_fm_status = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        do_read();
        check_status(1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int  op;
            bit  on_sel;
            op     = $urandom_range(0, 9);
            on_sel = ($urandom_range(0, 7) != 0);
            case (op)
                0, 1, 2: do_datao(rand36(), on_sel, 1'b0);
                3:       do_datao(rand36(), on_sel, 1'b1);
                4, 5:    do_read();
                6:       do_cono(1'($urandom), rand36(), on_sel);
                7:       check_status(on_sel);
                8:       key_tape_feed = ~key_tape_feed;
                default: if ($urandom_range(0, 3) == 0) do_iob_reset();
            endcase
            check_status(1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
